// File: rtl/copro_arb_if.sv
// Requester and coprocessor bus for copro_arb.
// master is the arbiter side; slave is the requesters plus coprocessor.
interface copro_arb_if #(parameter int N = 4);
    logic [N-1:0]    req;
    logic [32*N-1:0] opa;
    logic [32*N-1:0] opb;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done;
    logic [63:0]     res;
    logic            busy;
    logic            cp_start;
    logic            cp_ready;
    logic            cp_dpsh;
    logic [31:0]     cp_dinp;
    logic            cp_dpop;
    logic [31:0]     cp_dout;

    modport master (
        input  req, opa, opb, cp_ready, cp_dout,
        output gnt, done, res, busy,
        output cp_start, cp_dpsh, cp_dinp, cp_dpop
    );

    modport slave (
        output req, opa, opb, cp_ready, cp_dout,
        input  gnt, done, res, busy,
        input  cp_start, cp_dpsh, cp_dinp, cp_dpop
    );
endinterface

// File: rtl/copro_arb.sv
// Round-robin sharing of one 32x32 multiplier coprocessor, with a zero scrub
// after each job. COPRO_ARB_ZSKIP_EN short-circuits jobs with a zero operand.
module copro_arb #(
    parameter int N = 4
) (
    input logic         ck,
    input logic         rb,
    copro_arb_if.master bus
);
    localparam int IW = $clog2(N);

    typedef enum logic [3:0] {
        IDLE, PSHA, PSHB, STRT, WAIT, RDHI, RDLO, SPA, SPB, SST, SWT
    } st_t;

    st_t st, st_n;

    logic [IW-1:0] last, idx, sel, jj;
    logic          hit;
    logic          zs;
    logic [31:0]   sa, sb;
    logic [31:0]   a_q, b_q, hi_q;
    logic [63:0]   res_q;
    logic [N-1:0]  done_q;
    logic [N-1:0]  gnt_c;
    logic          start_c, dpsh_c, dpop_c;
    logic [31:0]   dinp_c;

    // first set request searching upward from last+1, with wrap
    always_comb begin
        sel = last;
        hit = 1'b0;
        jj  = last;
        for (int k = 1; k <= N; k++) begin
            jj = (int'(last) + k >= N) ? IW'(int'(last) + k - N)
                                       : IW'(int'(last) + k);
            if (!hit && bus.req[jj]) begin
                hit = 1'b1;
                sel = jj;
            end
        end
    end

    always_comb begin
        sa = '0;
        sb = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == IW'(i)) begin
                sa = bus.opa[32*i +: 32];
                sb = bus.opb[32*i +: 32];
            end
        end
    end

`ifdef COPRO_ARB_ZSKIP_EN
    assign zs = (sa == 32'd0) || (sb == 32'd0);
`else
    assign zs = 1'b0;
`endif

    always_comb begin
        st_n    = st;
        gnt_c   = '0;
        start_c = 1'b0;
        dpsh_c  = 1'b0;
        dpop_c  = 1'b0;
        dinp_c  = '0;
        unique case (st)
            IDLE: begin
                if (hit) begin
                    gnt_c[sel] = 1'b1;
                    st_n       = zs ? IDLE : PSHA;
                end
            end
            PSHA: begin
                dpsh_c = 1'b1;
                dinp_c = a_q;
                st_n   = PSHB;
            end
            PSHB: begin
                dpsh_c = 1'b1;
                dinp_c = b_q;
                st_n   = STRT;
            end
            STRT: begin
                start_c = 1'b1;
                st_n    = WAIT;
            end
            WAIT: if (bus.cp_ready) st_n = RDHI;
            RDHI: begin
                dpop_c = 1'b1;
                st_n   = RDLO;
            end
            RDLO: st_n = SPA;
            SPA: begin
                dpsh_c = 1'b1;
                st_n   = SPB;
            end
            SPB: begin
                dpsh_c = 1'b1;
                st_n   = SST;
            end
            SST: begin
                start_c = 1'b1;
                st_n    = SWT;
            end
            SWT: if (bus.cp_ready) st_n = IDLE;
            default: st_n = IDLE;
        endcase
    end

    always_ff @(posedge ck) begin
        if (!rb) begin
            st     <= IDLE;
            last   <= IW'(N - 1);
            idx    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            hi_q   <= '0;
            res_q  <= '0;
            done_q <= '0;
        end else begin
            st     <= st_n;
            done_q <= '0;
            if (st == IDLE && hit) begin
                last <= sel;
                idx  <= sel;
                a_q  <= sa;
                b_q  <= sb;
                if (zs) begin
                    res_q       <= '0;
                    done_q[sel] <= 1'b1;
                end
            end
            if (st == RDHI) hi_q <= bus.cp_dout;
            if (st == RDLO) begin
                res_q       <= {hi_q, bus.cp_dout};
                done_q[idx] <= 1'b1;
            end
        end
    end

    // no grant while reset is held, since nothing would be latched
    assign bus.gnt      = rb ? gnt_c : '0;
    assign bus.done     = done_q;
    assign bus.res      = res_q;
    assign bus.busy     = (st != IDLE);
    assign bus.cp_start = start_c;
    assign bus.cp_dpsh  = dpsh_c;
    assign bus.cp_dinp  = dinp_c;
    assign bus.cp_dpop  = dpop_c;
endmodule

// File: tb/tb_copro_arb.sv
// Bench for copro_arb: behavioural coprocessor with a sticky accumulator,
// plus a round-robin and product reference model.
module tb_copro_arb;
    localparam int N = 4;

`ifdef COPRO_ARB_ZSKIP_EN
    localparam bit ZSKIP = 1'b1;
`else
    localparam bit ZSKIP = 1'b0;
`endif

    logic ck = 1'b0;
    logic rb = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   m_last = N - 1;
    int   npush = 0;
    int   nstart = 0;

    copro_arb_if #(.N(N)) bus ();

    copro_arb #(.N(N)) dut (
        .ck  (ck),
        .rb  (rb),
        .bus (bus)
    );

    always #5 ck = ~ck;
    always @(posedge ck) cyc <= cyc + 1;

    // coprocessor: result = a*b + old high word; pop swaps hi/lo
    logic [31:0] c_op0, c_op1, c_hi, c_lo;
    int          c_cnt;
    logic        c_rdy;
    logic [63:0] c_p;
    assign c_p = {32'h0, c_op0} * {32'h0, c_op1} + {32'h0, c_hi};

    always @(posedge ck) begin
        if (!rb) begin
            c_op0 <= '0;
            c_op1 <= '0;
            c_hi  <= '0;
            c_lo  <= '0;
            c_cnt <= 0;
            c_rdy <= 1'b0;
        end else begin
            c_rdy <= 1'b0;
            if (bus.cp_dpsh) begin
                c_op0 <= c_op1;
                c_op1 <= bus.cp_dinp;
                npush <= npush + 1;
            end
            if (bus.cp_start) begin
                c_cnt  <= 32;
                nstart <= nstart + 1;
            end else if (c_cnt > 1) begin
                c_cnt <= c_cnt - 1;
            end else if (c_cnt == 1) begin
                c_cnt <= 0;
                c_rdy <= 1'b1;
                c_hi  <= c_p[63:32];
                c_lo  <= c_p[31:0];
            end
            if (bus.cp_dpop) begin
                c_hi <= c_lo;
                c_lo <= c_hi;
            end
        end
    end

    assign bus.cp_ready = c_rdy;
    assign bus.cp_dout  = c_hi;

    function automatic int rr_next(input int lst, input logic [N-1:0] m);
        rr_next = -1;
        for (int k = 1; k <= N; k++)
            if (rr_next < 0 && m[(lst + k) % N]) rr_next = (lst + k) % N;
    endfunction

    function automatic bit is_zs(input logic [31:0] a, input logic [31:0] b);
        return ZSKIP && (a == 0 || b == 0);
    endfunction

    function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
        return is_zs(a, b) ? 1 : 39;
    endfunction

    function automatic int exp_idle(input logic [31:0] a, input logic [31:0] b);
        return is_zs(a, b) ? 1 : 75;
    endfunction

    task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b);
        bus.opa[32*i +: 32] = a;
        bus.opb[32*i +: 32] = b;
        bus.req[i] = 1'b1;
    endtask

    task automatic wait_gnt(output int who, output int g);
        who = -1;
        g = -1;
        for (int t = 0; t < 200; t++) begin
            #1;
            if (bus.gnt != '0) begin
                g = cyc;
                for (int k = 0; k < N; k++) if (bus.gnt[k]) who = k;
                break;
            end
            @(negedge ck);
        end
    endtask

    task automatic wait_done(input int i, output int d, output logic [63:0] r);
        d = -1;
        r = '0;
        for (int t = 0; t < 200; t++) begin
            @(negedge ck);
            #1;
            if (bus.done[i]) begin
                d = cyc;
                r = bus.res;
                break;
            end
        end
    endtask

    task automatic wait_idle(output int c);
        c = -1;
        for (int t = 0; t < 200; t++) begin
            if (!bus.busy) begin
                c = cyc;
                break;
            end
            @(negedge ck);
            #1;
        end
    endtask

    task automatic drop_after_edge(input int i);
        @(posedge ck);
        #1;
        bus.req[i] = 1'b0;
    endtask

    task automatic test_reset;
        rb = 1'b0;
        bus.req = '0;
        bus.opa = '0;
        bus.opb = '0;
        repeat (3) @(negedge ck);
        bus.req = '1;
        #1;
        total++;
        if ({bus.gnt, bus.done, bus.res, bus.busy, bus.cp_start, bus.cp_dpsh,
             bus.cp_dpop, bus.cp_dinp} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got gnt=%b done=%b res=%h busy=%b st=%b psh=%b pop=%b dinp=%h want all 0",
                     bus.gnt, bus.done, bus.res, bus.busy, bus.cp_start,
                     bus.cp_dpsh, bus.cp_dpop, bus.cp_dinp);
        end
        @(negedge ck);
        bus.req = '0;
        rb = 1'b1;
        m_last = N - 1;
    endtask

    task automatic test_simple;
        int w, g, d, c;
        logic [63:0] r;
        @(negedge ck);
        issue(0, 32'd3, 32'd5);
        wait_gnt(w, g);
        total++;
        if (w !== 0) begin
            bad++;
            $display("FAIL simple_gnt got %0d want 0", w);
        end
        m_last = 0;
        drop_after_edge(0);
        wait_done(0, d, r);
        total++;
        if (d !== g + 39 || r !== 64'hF) begin
            bad++;
            $display("FAIL simple_done got cyc=%0d res=%h want cyc=%0d res=%h",
                     d, r, g + 39, 64'hF);
        end
        wait_idle(c);
        total++;
        if (c !== g + 75) begin
            bad++;
            $display("FAIL simple_idle got %0d want %0d", c, g + 75);
        end
    endtask

    task automatic test_scrub;
        int w, g, d, c;
        logic [63:0] r;
        logic [31:0] av [2];
        logic [31:0] bv [2];
        av[0] = 32'hFFFF_FFFF; bv[0] = 32'hFFFF_FFFF;
        av[1] = 32'h0001_0000; bv[1] = 32'h0001_0000;
        for (int j = 0; j < 2; j++) begin
            @(negedge ck);
            issue(1, av[j], bv[j]);
            wait_gnt(w, g);
            total++;
            if (w !== 1) begin
                bad++;
                $display("FAIL scrub_gnt%0d got %0d want 1", j, w);
            end
            m_last = 1;
            drop_after_edge(1);
            wait_done(1, d, r);
            total++;
            if (d !== g + 39 || r !== 64'(av[j]) * 64'(bv[j])) begin
                bad++;
                $display("FAIL scrub_res%0d got cyc=%0d res=%h want cyc=%0d res=%h",
                         j, d, r, g + 39, 64'(av[j]) * 64'(bv[j]));
            end
            wait_idle(c);
        end
    endtask

    task automatic test_round_robin;
        int w, g, d, e, c;
        logic [63:0] r;
        logic [N-1:0] m;
        logic [31:0] av [N];
        logic [31:0] bv [N];
        @(negedge ck);
        for (int i = 0; i < N; i++) begin
            av[i] = $urandom | 32'h1;
            bv[i] = $urandom | 32'h1;
            issue(i, av[i], bv[i]);
        end
        m = '1;
        for (int k = 0; k < 6; k++) begin
            wait_gnt(w, g);
            e = rr_next(m_last, m);
            total++;
            if (w !== e) begin
                bad++;
                $display("FAIL rr_gnt%0d got %0d want %0d", k, w, e);
            end
            m_last = e;
            if (e < 0) break;
            if (k == 4) begin
                @(posedge ck);
                #1;
                m = 4'b0101;
                bus.req = m;
            end else if (k == 5) begin
                drop_after_edge(e);
                m = '0;
            end
            wait_done(e, d, r);
            total++;
            if (r !== 64'(av[e]) * 64'(bv[e])) begin
                bad++;
                $display("FAIL rr_res%0d got %h want %h", k, r, 64'(av[e]) * 64'(bv[e]));
            end
        end
        bus.req = '0;
        wait_idle(c);
    endtask

    task automatic test_reset_mid;
        int w, g, d, c, nd;
        logic [63:0] r;
        @(negedge ck);
        issue(1, $urandom | 32'h1, $urandom | 32'h1);
        wait_gnt(w, g);
        drop_after_edge(1);
        repeat (9) @(negedge ck);
        rb = 1'b0;
        @(posedge ck);
        #1;
        total++;
        if ({bus.gnt, bus.done, bus.res, bus.busy, bus.cp_start, bus.cp_dpsh,
             bus.cp_dpop, bus.cp_dinp} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs got done=%b res=%h busy=%b st=%b psh=%b pop=%b want all 0",
                     bus.done, bus.res, bus.busy, bus.cp_start, bus.cp_dpsh, bus.cp_dpop);
        end
        @(negedge ck);
        rb = 1'b1;
        m_last = N - 1;
        nd = 0;
        for (int t = 0; t < 60; t++) begin
            @(negedge ck);
            #1;
            if (bus.done != '0) nd++;
        end
        total++;
        if (nd !== 0) begin
            bad++;
            $display("FAIL midreset_nodone got %0d done pulses want 0", nd);
        end
        @(negedge ck);
        issue(2, 32'd7, 32'd6);
        wait_gnt(w, g);
        total++;
        if (w !== rr_next(m_last, 4'b0100)) begin
            bad++;
            $display("FAIL midreset_gnt got %0d want 2", w);
        end
        m_last = 2;
        drop_after_edge(2);
        wait_done(2, d, r);
        total++;
        if (d !== g + 39 || r !== 64'd42) begin
            bad++;
            $display("FAIL midreset_job got cyc=%0d res=%h want cyc=%0d res=%h",
                     d, r, g + 39, 64'd42);
        end
        wait_idle(c);
    endtask

    task automatic test_zero;
        int w, g, d, c, p0, s0;
        logic [63:0] r;
        @(negedge ck);
        p0 = npush;
        s0 = nstart;
        issue(3, 32'd0, 32'h1234);
        wait_gnt(w, g);
        m_last = 3;
        drop_after_edge(3);
        wait_done(3, d, r);
        total++;
        if (d !== g + exp_lat(32'd0, 32'h1234) || r !== 64'd0) begin
            bad++;
            $display("FAIL zero_done got cyc=%0d res=%h want cyc=%0d res=0",
                     d, r, g + exp_lat(32'd0, 32'h1234));
        end
        wait_idle(c);
        total++;
        if (npush - p0 !== (ZSKIP ? 0 : 4) || nstart - s0 !== (ZSKIP ? 0 : 2)) begin
            bad++;
            $display("FAIL zero_activity got push=%0d start=%0d want push=%0d start=%0d",
                     npush - p0, nstart - s0, ZSKIP ? 0 : 4, ZSKIP ? 0 : 2);
        end
    endtask

    task automatic test_random;
        int i, w, g, d, c;
        logic [63:0] r;
        logic [31:0] a, b;
        for (int k = 0; k < 10; k++) begin
            i = $urandom_range(0, N - 1);
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) a = '0;
            if ($urandom_range(0, 4) == 0) b = '0;
            @(negedge ck);
            issue(i, a, b);
            wait_gnt(w, g);
            total++;
            if (w !== i) begin
                bad++;
                $display("FAIL rand_gnt%0d got %0d want %0d", k, w, i);
            end
            m_last = i;
            drop_after_edge(i);
            wait_done(i, d, r);
            total++;
            if (d !== g + exp_lat(a, b) || r !== 64'(a) * 64'(b)) begin
                bad++;
                $display("FAIL rand_job%0d got cyc=%0d res=%h want cyc=%0d res=%h",
                         k, d, r, g + exp_lat(a, b), 64'(a) * 64'(b));
            end
            wait_idle(c);
            total++;
            if (c !== g + exp_idle(a, b)) begin
                bad++;
                $display("FAIL rand_idle%0d got %0d want %0d", k, c, g + exp_idle(a, b));
            end
        end
    endtask

    initial begin
        test_reset;
        test_simple;
        test_scrub;
        test_round_robin;
        test_reset_mid;
        test_zero;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/copro_arb.md
# copro_arb

Round-robin arbiter and sequencer that shares one 32x32 unsigned multiplier coprocessor between N requesters. It grants one requester at a time, drives the coprocessor's push/start/pop protocol, and returns the 64-bit product with a done pulse. After every job it runs a zero-operand scrub pass, because the coprocessor does not clear its accumulator on start.

## Interface
- N, 4, number of requesters (2..8)
- ck  in  1  clock
- rb  in  1  reset; one clock; reset is synchronous and active-low
- req  in  N  per-requester request level
- opa  in  32*N  requester i operand A at [32*i+31:32*i]
- opb  in  32*N  requester i operand B
- gnt  out  N  one-hot, one-cycle grant pulse; operands sampled this cycle
- done  out  N  one-hot, one-cycle completion pulse
- res  out  64  product; valid with done, held until next done
- busy  out  1  state != IDLE
- cp_start  out  1  coprocessor start
- cp_ready  in  1  coprocessor ready pulse
- cp_dpsh  out  1  coprocessor operand push
- cp_dinp  out  32  coprocessor push data
- cp_dpop  out  1  coprocessor result pop/swap
- cp_dout  in  32  coprocessor output (high word, then low word after one pop)

## Operation
- Coprocessor contract:
  - Two pushes load the operands.
  - Start runs 32 active cycles.
  - cp_ready pulses on the cycle after the last active cycle.
  - cp_dout then shows the high word; one pop exposes the low word.
  - The accumulator high word must be 0 before start.
- FSM states: IDLE, PSHA, PSHB, STRT, WAIT, RDHI, RDLO, SPA, SPB, SST, SWT.
- IDLE:
  - If any req is set: pick the first set index searching upward, with wrap, from last+1.
  - Pulse gnt[idx]; latch opa/opb/idx; update last; go to PSHA.
- PSHA: cp_dpsh=1, cp_dinp=opa.
- PSHB: cp_dpsh=1, cp_dinp=opb.
- STRT: cp_start=1.
- WAIT: stay until cp_ready.
- RDHI: capture cp_dout as hi; cp_dpop=1.
- RDLO: capture cp_dout as lo; register res={hi,lo}; done[idx] is asserted the following cycle.
- SPA, SPB: cp_dpsh=1, cp_dinp=0.
- SST: cp_start=1.
- SWT: wait for cp_ready, then go to IDLE.
- Outputs not listed for a state are 0; cp_dinp=0 outside push states.
- Requests are sampled only in IDLE. A requester must hold req until gnt; dropping req before gnt means it is not served. Requests arriving while busy wait.
- cp_ready outside WAIT/SWT is ignored.
- Reset values: all outputs 0, state IDLE, last=N-1 (index 0 has first priority), res=0.
- Reset asserted mid-operation: at the next edge the FSM returns to IDLE and all outputs go to 0. No done is issued for the aborted job. The coprocessor shares rb, so its accumulator is also 0.

## Timing
- Grant in cycle G, then:
  - PSHA G+1, PSHB G+2, STRT G+3.
  - Coprocessor active G+4..G+35; cp_ready at G+36.
  - RDHI G+37, RDLO G+38.
  - done/res valid G+39, coinciding with SPA.
- Scrub: SST G+41, cp_ready G+74, IDLE G+75.
- Earliest next gnt is G+75, giving a throughput of one job per 75 cycles.
- gnt and done are never asserted in the same cycle for the same job.

## Configuration
- COPRO_ARB_ZSKIP_EN defined:
  - In IDLE, if the selected requester has opa==0 or opb==0: pulse gnt at G and done at G+1 with res=0.
  - No coprocessor activity and no scrub; return to IDLE at G+1, so the next gnt can be at G+1.
- COPRO_ARB_ZSKIP_EN undefined: zero operands take the full 75-cycle path.

## Test plan
- **Simple product:** req[0] with 3 x 5 -> gnt[0] at G; done[0] at G+39 with res=0x000000000000000F; busy low at G+75.
- **Full-width product:** 0xFFFFFFFF x 0xFFFFFFFF -> res=0xFFFFFFFE00000001.
- **Scrub check:** job 0x10000 x 0x10000 issued directly after the full-width job -> res=0x0000000100000000, with no residue from the previous job.
- **Round-robin order:** req=4'b1111 held, one job per grant -> gnt order 0,1,2,3,0. Then req=4'b0101 with last=0 -> next gnt is 2.
- **Reset mid-operation:** rb low during WAIT -> all outputs 0 at the next edge and no done. A following 7 x 6 job returns res=42 at G+39.
- **Zero-skip:** opa=0, opb=0x1234 -> with the macro, done at G+1, res=0, cp_dpsh/cp_start never asserted. Without the macro, done at G+39, res=0.
